lsu_controller: RTL and testbench

Load/store sequencer between the core's memory stage and the word-addressed data bus. It accepts one byte, halfword or word access at a time. It converts the access into one or two word-aligned bus transactions with byte enables and lane-shifted write data, then returns sign- or zero-extended load data and a completion pulse to the core.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_extend.sv | 34 +++
 rtl/lsu_controller.sv | 181 ++++++++++++++++++
 tb/tb_lsu_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared types for the load/store sequencer:
//     lsu_size_e  - access size encoding as presented on the request port
//     lsu_state_e - sequencer FSM states
//     size_mask() - byte-lane mask of an access before it is shifted by the offset
package lsu_pkg;

  // 2'b11 is not a distinct size; it is handled exactly like a word access.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input lsu_size_e size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend
//   Combinational load-result formatter. Shifts the two fetched words right
//   by the byte offset and sign- or zero-extends the selected byte/halfword.
//   Ports:
//     rdata       in  64  {second word, first word}; second word is 0 when unused
//     off         in  2   byte offset of the access within the first word
//     size        in  2   access size (lsu_size_e)
//     is_unsigned in  1   zero-extend instead of sign-extend
//     result      out 32  load data as returned to the core
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [1:0]  off,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] rd32;

  assign rd32 = 32'(rdata >> {off, 3'b000});

  always_comb begin
    // NOTE: default assignment first, so every path drives result and no latch is inferred.
    result = rd32;
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & rd32[7]}}, rd32[7:0]};
      SZ_HALF: result = {{16{~is_unsigned & rd32[15]}}, rd32[15:0]};
      default: result = rd32;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// lsu_controller
//   Load/store sequencer between the core memory stage and a word-addressed
//   data bus. One byte/halfword/word access at a time is turned into one or
//   two word-aligned bus transactions; load data is returned extended.
//
//   Build option: MISALIGNED_SPLIT_EN
//     defined   - word-crossing accesses are split into two bus transactions
//     undefined - word-crossing accesses complete at once with o_rsp_err=1
//
//   Ports:
//     i_clk, i_rst                  clock, asynchronous active-high reset
//     i_req_*, o_req_ready          core request (accepted only in IDLE)
//     o_rsp_valid/rdata/err         one-cycle completion pulse to the core
//     o_bus_*, i_bus_ready          bus request, held stable until ready
//     i_bus_ack, i_bus_rdata        bus completion and read data
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_bus_valid,
  input  logic                  i_bus_ready,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [3:0]            o_bus_be,
  output logic [31:0]           o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [31:0]           i_bus_rdata
);

  lsu_state_e            state;
  logic                  we_q;
  lsu_size_e             size_q;
  logic                  unsigned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_hi_q;   // byte enables of the second word (0 = no crossing)
  logic [31:0]           wd_hi_q;   // store data of the second word
  logic [31:0]           rdata0_q;
  logic [31:0]           rdata1_q;

  // Lane computation on the incoming request; only ever captured into registers.
  lsu_size_e   in_size;
  logic [7:0]  in_be8;
  logic [63:0] in_wd64;

  assign in_size = lsu_size_e'(i_req_size);
  assign in_be8  = {4'b0000, size_mask(in_size)} << i_req_addr[1:0];
  assign in_wd64 = {32'b0, i_req_wdata} << {i_req_addr[1:0], 3'b000};

`ifndef MISALIGNED_SPLIT_EN
  logic in_cross;
  assign in_cross = |in_be8[7:4];
`endif

  logic [ADDR_WIDTH-1:0] word_addr_q;
  assign word_addr_q = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  logic [31:0] load_result;

  lsu_load_extend u_extend (
    .rdata       ({rdata1_q, rdata0_q}),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (load_result)
  );

  // Read data is presented only during the RESP pulse of a successful load.
  assign o_rsp_rdata = (state == RESP && !we_q && !o_rsp_err) ? load_result : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_bus_valid <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_be    <= '0;
      o_bus_wdata <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            we_q        <= i_req_we;
            size_q      <= in_size;
            unsigned_q  <= i_req_unsigned;
            addr_q      <= i_req_addr;
            be_hi_q     <= in_be8[7:4];
            wd_hi_q     <= in_wd64[63:32];
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifndef MISALIGNED_SPLIT_EN
            if (in_cross) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else
`endif
            begin
              state       <= REQ0;
              o_bus_valid <= 1'b1;
              o_bus_we    <= i_req_we;
              o_bus_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              o_bus_be    <= in_be8[3:0];
              o_bus_wdata <= in_wd64[31:0];
            end
          end
        end

        REQ0, REQ1: begin
          if (i_bus_ready) begin
            state       <= (state == REQ0) ? WAIT0 : WAIT1;
            o_bus_valid <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
          end
        end

        WAIT0: begin
          if (i_bus_ack) begin
            rdata0_q <= i_bus_rdata;
            if (|be_hi_q) begin
              state       <= REQ1;
              o_bus_valid <= 1'b1;
              o_bus_we    <= we_q;
              o_bus_addr  <= word_addr_q + ADDR_WIDTH'(4);  // wraps at the top of memory
              o_bus_be    <= be_hi_q;
              o_bus_wdata <= wd_hi_q;
            end else begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
            end
          end
        end

        WAIT1: begin
          if (i_bus_ack) begin
            rdata1_q    <= i_bus_rdata;
            state       <= RESP;
            o_rsp_valid <= 1'b1;
          end
        end

        RESP: begin
          state       <= IDLE;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_req_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller
//   Scoreboard bench for lsu_controller. Stimulus pushes expected bus
//   transactions and expected responses into queues; a bus agent and a
//   response monitor pop and compare independently. Expectations follow the
//   MISALIGNED_SPLIT_EN setting of the build.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_bus_valid;
  logic        i_bus_ready = 1'b0;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  always #5 clk = ~clk;

  lsu_controller #(.ADDR_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_bus_valid    (o_bus_valid),
    .i_bus_ready    (i_bus_ready),
    .o_bus_we       (o_bus_we),
    .o_bus_addr     (o_bus_addr),
    .o_bus_be       (o_bus_be),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_ack      (i_bus_ack),
    .i_bus_rdata    (i_bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  rsp_t        exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int txn_count = 0;
  int stall_cfg = 0;
  int hold_at = 1 << 30;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus agent: stalls ready for stall_cfg cycles, acks one cycle after acceptance.
  int          stall_cnt = 0;
  bit          ack_pend = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [4:0]  snap_ctl;

  always @(negedge clk) begin
    bus_t e;
    i_bus_ready = 1'b0;
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    if (i_rst) begin
      stall_cnt = 0;
      ack_pend  = 0;
      bus_q.delete();
      rd_q.delete();
    end else if (o_bus_valid) begin
      if (stall_cnt == 0) begin
        snap_addr  = o_bus_addr;
        snap_wdata = o_bus_wdata;
        snap_ctl   = {o_bus_we, o_bus_be};
      end else begin
        check("stall_addr", 64'(o_bus_addr), 64'(snap_addr));
        check("stall_wdata", 64'(o_bus_wdata), 64'(snap_wdata));
        check("stall_we_be", 64'({o_bus_we, o_bus_be}), 64'(snap_ctl));
      end
      if (stall_cnt < stall_cfg) begin
        stall_cnt++;
      end else begin
        stall_cnt   = 0;
        i_bus_ready = 1'b1;
        ack_pend    = 1;
        txn_count++;
        if (bus_q.size() == 0) begin
          check("bus_unexpected", 64'(o_bus_valid), 64'(0));
        end else begin
          e = bus_q.pop_front();
          check("bus_we", 64'(o_bus_we), 64'(e.we));
          check("bus_addr", 64'(o_bus_addr), 64'(e.addr));
          check("bus_be", 64'(o_bus_be), 64'(e.be));
          check("bus_wdata", 64'(o_bus_wdata), 64'(e.wdata));
        end
      end
    end else if (ack_pend && txn_count < hold_at) begin
      ack_pend    = 0;
      i_bus_ack   = 1'b1;
      i_bus_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t r;
    if (!i_rst && o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(o_rsp_valid), 64'(0));
      end else begin
        r = exp_q.pop_front();
        check("rsp_rdata", 64'(o_rsp_rdata), 64'(r.rdata));
        check("rsp_err", 64'(o_rsp_err), 64'(r.err));
        check("rsp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
  end

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    bus_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    bus_q.push_back(e);
    rd_q.push_back(rdata);
  endtask

  // lat: cycles from the accepting edge to the edge that raises o_rsp_valid.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input bit want_rsp);
    int   n = 0;
    rsp_t r;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(o_req_ready), 64'(1));
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    @(posedge clk);
    #1;
    if (want_rsp) begin
      r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
      exp_q.push_back(r);
    end
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_wdata = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !o_req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drain", 64'(exp_q.size()), 64'(0));
    check("bus_drain", 64'(bus_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(o_req_ready), 64'(1));
    check("rst_bus_valid", 64'(o_bus_valid), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(o_rsp_rdata), 64'(0));
    check("rst_bus_addr", 64'(o_bus_addr), 64'(0));
    i_rst = 1'b0;

    // Aligned word load.
    exp_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1);
    wait_idle();

    // Byte store into the top lane; read data on the ack must not leak out.
    exp_bus(1'b1, 32'h0000_0200, 4'b1000, 32'hA500_0000, 32'hFFFF_FFFF);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1'b0, 2, 1);
    wait_idle();

    // Halfword loads, signed then unsigned.
    exp_bus(1'b0, 32'h0000_0100, 4'b1100, 32'h0, 32'h8001_0000);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1);
    wait_idle();
    exp_bus(1'b0, 32'h0000_0100, 4'b1100, 32'h0, 32'h8001_0000);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_8001, 1'b0, 2, 1);
    wait_idle();

    // Signed byte load from lane 3.
    exp_bus(1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h9A00_0000);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_FF9A, 1'b0, 2, 1);
    wait_idle();

    // Misaligned halfword that stays inside one word.
    exp_bus(1'b0, 32'h0000_0104, 4'b0110, 32'h0, 32'h00AB_CD00);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0105, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 1);
    wait_idle();

    // Size 2'b11 behaves as a word.
    exp_bus(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'h0BAD_F00D);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 1);
    wait_idle();

`ifdef MISALIGNED_SPLIT_EN
    // Word load crossing into the next word: two transactions.
    exp_bus(1'b0, 32'h0000_00FC, 4'b1100, 32'h0, 32'h2211_AAAA);
    exp_bus(1'b0, 32'h0000_0100, 4'b0011, 32'h0, 32'hBBBB_4433);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0, 32'h4433_2211, 1'b0, 4, 1);
    wait_idle();

    // Word store crossing the top of the address space.
    exp_bus(1'b1, 32'hFFFF_FFFC, 4'b1110, 32'h2233_4400, 32'h0);
    exp_bus(1'b1, 32'h0000_0000, 4'b0001, 32'h0000_0011, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFD, 32'h1122_3344, 32'h0, 1'b0, 4, 1);
    wait_idle();
`else
    // Crossing accesses complete at once with an error and no bus traffic.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0, 32'h0, 1'b1, 0, 1);
    wait_idle();
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFD, 32'h1122_3344, 32'h0, 1'b1, 0, 1);
    wait_idle();
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0107, 32'h0, 32'h0, 1'b1, 0, 1);
    wait_idle();
`endif

    // Ready held low for three cycles in REQ0.
    stall_cfg = 3;
    exp_bus(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 32'hCAFE_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0, 5, 1);
    wait_idle();
    stall_cfg = 0;

    // Reset while the final bus transaction of an access is outstanding.
`ifdef MISALIGNED_SPLIT_EN
    target  = txn_count + 2;
    hold_at = target;
    exp_bus(1'b0, 32'h0000_00FC, 4'b1100, 32'h0, 32'h2211_AAAA);
    exp_bus(1'b0, 32'h0000_0100, 4'b0011, 32'h0, 32'hBBBB_4433);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0, 32'h0, 1'b0, 0, 0);
`else
    target  = txn_count + 1;
    hold_at = target;
    exp_bus(1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'h5555_5555);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 1'b0, 0, 0);
`endif
    begin
      int n = 0;
      while (txn_count < target && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_rst_setup", 64'(txn_count), 64'(target));
    @(posedge clk);
    #1;
    check("mid_rst_pre_ready", 64'(o_req_ready), 64'(0));
    i_rst = 1'b1;
    #1;
    check("mid_rst_req_ready", 64'(o_req_ready), 64'(1));
    check("mid_rst_bus_valid", 64'(o_bus_valid), 64'(0));
    check("mid_rst_bus_addr", 64'(o_bus_addr), 64'(0));
    check("mid_rst_bus_be", 64'(o_bus_be), 64'(0));
    check("mid_rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("mid_rst_rsp_rdata", 64'(o_rsp_rdata), 64'(0));
    @(negedge clk);
    #2;
    i_rst   = 1'b0;
    hold_at = 1 << 30;
    repeat (3) @(negedge clk);

    // Normal operation resumes after the abandoned access.
    exp_bus(1'b0, 32'h0000_0400, 4'b1111, 32'h0, 32'h1357_2468);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h1357_2468, 1'b0, 2, 1);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
